// File: rtl/robot_nav_fsm.sv
// Two-motor robot navigation FSM with synchronised/debounced obstacle sensor, timed turns and
// automatic back-up-and-turn avoidance. Optional PWM motor gating when PWM_GATE_EN is defined.
module robot_nav_fsm #(
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 4,
    parameter int BACK_CYCLES = 8,
    parameter int TURN_CYCLES = 12,
    parameter int PWM_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             S,
    input  logic [2:0]       I,
    input  logic [PWM_W-1:0] speed,
    output logic [1:0]       M1,
    output logic [1:0]       M2,
    output logic [2:0]       L,
    output logic             obst
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FWD        = 3'd1,
        REV        = 3'd2,
        TURN_L     = 3'd3,
        TURN_R     = 3'd4,
        AVOID_BACK = 3'd5,
        AVOID_TURN = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] BACK_LOAD = CNT_W'(BACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic             sync1_q, sync2_q;
    logic             obst_q, obst_d;
    logic [2:0]       last_q;
    logic [1:0]       m1_q, m1_d, m2_q, m2_d;
    logic [2:0]       l_q;

`ifdef PWM_GATE_EN
    logic [PWM_W-1:0] pwm_q, pwm_d;
`else
    logic unused_speed;
    assign unused_speed = ^speed;
`endif

    // Debounce: obst flips only after DEB_CYCLES consecutive mismatching synced samples.
    always_comb begin
        deb_d  = '0;
        obst_d = obst_q;
        if (sync2_q != obst_q) begin
            if (deb_q == DEB_LAST) begin
                obst_d = ~obst_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (I == 3'b000) begin
            state_d = IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                TURN_L, TURN_R: begin
                    if (phase_q == '0) state_d = IDLE;
                    else               phase_d = phase_q - 1'b1;
                end
                AVOID_BACK: begin
                    if (phase_q == '0) begin
                        state_d = AVOID_TURN;
                        phase_d = TURN_LOAD;
                    end else begin
                        phase_d = phase_q - 1'b1;
                    end
                end
                AVOID_TURN: begin
                    if (phase_q != '0) begin
                        phase_d = phase_q - 1'b1;
                    end else if (I == 3'b001 && obst_q) begin
                        state_d = AVOID_BACK;
                        phase_d = BACK_LOAD;
                    end else if (I == 3'b001) begin
                        state_d = FWD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    if (state_q == FWD && obst_q) begin
                        state_d = AVOID_BACK;
                        phase_d = BACK_LOAD;
                    end else begin
                        case (I)
                            3'b001: begin
                                if (obst_q) begin
                                    state_d = AVOID_BACK;
                                    phase_d = BACK_LOAD;
                                end else begin
                                    state_d = FWD;
                                end
                            end
                            3'b010: state_d = REV;
                            // Turns are edge-triggered on the command so a held turn fires once.
                            3'b011: if (last_q != I) begin
                                state_d = TURN_L;
                                phase_d = TURN_LOAD;
                            end
                            3'b100: if (last_q != I) begin
                                state_d = TURN_R;
                                phase_d = TURN_LOAD;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        m1_d = 2'b00;
        m2_d = 2'b00;
        case (state_d)
            FWD:        begin m1_d = 2'b10; m2_d = 2'b10; end
            REV:        begin m1_d = 2'b01; m2_d = 2'b01; end
            TURN_L:     begin m1_d = 2'b01; m2_d = 2'b10; end
            TURN_R:     begin m1_d = 2'b10; m2_d = 2'b01; end
            AVOID_BACK: begin m1_d = 2'b01; m2_d = 2'b01; end
            AVOID_TURN: begin m1_d = 2'b10; m2_d = 2'b01; end
            default:    ;
        endcase
`ifdef PWM_GATE_EN
        pwm_d = pwm_q + 1'b1;
        if (!(pwm_d < speed)) begin
            m1_d = 2'b00;
            m2_d = 2'b00;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            deb_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            obst_q  <= 1'b0;
            last_q  <= 3'b000;
            m1_q    <= 2'b00;
            m2_q    <= 2'b00;
            l_q     <= 3'b000;
`ifdef PWM_GATE_EN
            pwm_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            deb_q   <= deb_d;
            sync1_q <= S;
            sync2_q <= sync1_q;
            obst_q  <= obst_d;
            last_q  <= I;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            l_q     <= state_d;
`ifdef PWM_GATE_EN
            pwm_q   <= pwm_d;
`endif
        end
    end

    assign M1   = m1_q;
    assign M2   = m2_q;
    assign L    = l_q;
    assign obst = obst_q;

endmodule

// File: tb/tb_robot_nav_fsm.sv
// Self-checking bench for robot_nav_fsm: cycle-level behavioural model plus directed scenarios.
module tb_robot_nav_fsm;
    localparam int PWM_W = 4;
    localparam int DEB   = 4;
    localparam int BACK  = 8;
    localparam int TURN  = 12;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             S     = 1'b0;
    logic [2:0]       I     = 3'b000;
    logic [PWM_W-1:0] speed = '0;
    logic [1:0]       M1, M2;
    logic [2:0]       L;
    logic             obst;

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    robot_nav_fsm dut (
        .clk(clk), .reset(reset), .S(S), .I(I), .speed(speed),
        .M1(M1), .M2(M2), .L(L), .obst(obst)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_L(int exp, int maxc, string name);
        int k;
        k = 0;
        while (int'(L) != exp && k < maxc) begin
            cyc();
            k++;
        end
        chk(name, int'(L), exp);
    endtask

    // Model: mode is the L code, left counts remaining cycles of a timed activity.
    int       m_mode = 0;
    int       m_left = 0;
    int       m_run  = 0;
    int       m_k    = 0;
    bit       m_obst = 1'b0;
    logic [2:0] m_last = 3'b000;
    bit       s_hist[$];

    function automatic int dur(int md);
        return (md == 5) ? BACK : TURN;
    endfunction

    function automatic int motor(int md, bit right);
        int v;
        case (md)
            1: v = 2;
            2: v = 1;
            3: v = right ? 2 : 1;
            4: v = right ? 1 : 2;
            5: v = 1;
            6: v = right ? 1 : 2;
            default: v = 0;
        endcase
`ifdef PWM_GATE_EN
        if (!(m_k < int'(speed))) v = 0;
`endif
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_left = 0; m_run = 0; m_k = 0; m_obst = 1'b0; m_last = 3'b000;
            s_hist.delete();
        end else begin : step
            int nm;
            bit sv;
            nm = m_mode;
            if (I == 3'b000) begin
                nm = 0;
            end else if (m_mode >= 3) begin
                if (m_left > 1) m_left--;
                else if (m_mode == 3 || m_mode == 4) nm = 0;
                else if (m_mode == 5) nm = 6;
                else nm = (I == 3'b001) ? (m_obst ? 5 : 1) : 0;
            end else if (m_mode == 1 && m_obst) begin
                nm = 5;
            end else if (I == 3'b001) begin
                nm = m_obst ? 5 : 1;
            end else if (I == 3'b010) begin
                nm = 2;
            end else if ((I == 3'b011 || I == 3'b100) && I != m_last) begin
                nm = int'(I);
            end
            if (nm >= 3 && nm != m_mode) m_left = dur(nm);
            m_mode = nm;
            m_last = I;
            // The debouncer sees the sensor value sampled two edges earlier.
            s_hist.push_back(S);
            if (s_hist.size() > 3) void'(s_hist.pop_front());
            sv = (s_hist.size() == 3) ? s_hist[0] : 1'b0;
            if (sv != m_obst) begin
                m_run++;
                if (m_run == DEB) begin
                    m_obst = ~m_obst;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_k = (m_k + 1) % (1 << PWM_W);
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("model_L", int'(L), m_mode);
            chk("model_M1", int'(M1), motor(m_mode, 1'b0));
            chk("model_M2", int'(M2), motor(m_mode, 1'b1));
            chk("model_obst", int'(obst), int'(m_obst));
        end
    end

    initial begin
        int cnt;
        #2 reset = 1'b1;
        cyc(); cyc();
        chk("rst_L", int'(L), 0); chk("rst_M1", int'(M1), 0);
        chk("rst_M2", int'(M2), 0); chk("rst_obst", int'(obst), 0);
        reset = 1'b0;
        cyc();

        // Basic commands
        I = 3'b001; cyc();
        chk("fwd_L", int'(L), 1); chk("fwd_M1", int'(M1), 2); chk("fwd_M2", int'(M2), 2);
        I = 3'b010; cyc();
        chk("rev_L", int'(L), 2); chk("rev_M1", int'(M1), 1); chk("rev_M2", int'(M2), 1);
        I = 3'b000; cyc();
        chk("stop_L", int'(L), 0);

        // Obstacle during FWD: back-up 8 cycles, turn 12, then back-up again while blocked
        I = 3'b001; cyc();
        chk("fwd2_L", int'(L), 1);
        S = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("obst_early", int'(obst), 0);
        end
        cyc();
        chk("obst_rise", int'(obst), 1); chk("obst_rise_L", int'(L), 1);
        cyc();
        chk("back_L", int'(L), 5); chk("back_M1", int'(M1), 1); chk("back_M2", int'(M2), 1);
        for (int k = 0; k < BACK - 1; k++) begin
            cyc();
            chk("back_hold", int'(L), 5);
        end
        for (int k = 0; k < TURN; k++) begin
            cyc();
            chk("aturn_hold", int'(L), 6);
        end
        cyc();
        chk("reback_L", int'(L), 5);
        S = 1'b0;
        wait_L(1, 40, "fwd_resume");
        I = 3'b000; cyc();
        chk("stop2_L", int'(L), 0);

        // Short sensor glitch is rejected; stop aborts AVOID_TURN
        I = 3'b001; cyc();
        S = 1'b1; cyc(); cyc(); cyc();
        S = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("glitch_obst", int'(obst), 0);
            chk("glitch_L", int'(L), 1);
        end
        S = 1'b1;
        wait_L(6, 40, "reach_aturn");
        I = 3'b000; cyc();
        chk("abort_L", int'(L), 0);
        S = 1'b0;
        repeat (8) cyc();
        chk("obst_fall", int'(obst), 0);

        // Held turn fires once for exactly TURN cycles, re-arms after leaving the code
        I = 3'b011;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (L == 3'b011) cnt++;
        end
        chk("turn_len", cnt, TURN);
        chk("turn_end_L", int'(L), 0);
        I = 3'b101; cyc();
        chk("noop_L", int'(L), 0);
        I = 3'b011; cyc();
        chk("return_L", int'(L), 3); chk("tl_M1", int'(M1), 1); chk("tl_M2", int'(M2), 2);
        I = 3'b000; cyc();
        I = 3'b100; cyc();
        chk("tr_L", int'(L), 4); chk("tr_M1", int'(M1), 2); chk("tr_M2", int'(M2), 1);
        repeat (TURN) cyc();
        chk("tr_end_L", int'(L), 0);
        I = 3'b000; cyc();

        // Reset in the middle of AVOID_BACK
        I = 3'b001; S = 1'b1;
        wait_L(5, 20, "back_reach");
        cyc();
        reset = 1'b1;
        #1;
        chk("mrst_L", int'(L), 0); chk("mrst_M1", int'(M1), 0);
        chk("mrst_M2", int'(M2), 0); chk("mrst_obst", int'(obst), 0);
        cyc();
        reset = 1'b0; I = 3'b000;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("post_rst_L", int'(L), 0);
        end
        S = 1'b0;
        repeat (8) cyc();

        // Speed gating (ungated unless PWM_GATE_EN)
        speed = 4'd4; I = 3'b001; cyc();
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (M1 == 2'b10) cnt++;
        end
`ifdef PWM_GATE_EN
        chk("pwm_on_4", cnt, 4);
`else
        chk("pwm_on_4", cnt, 16);
`endif
        speed = 4'd0;
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (M1 == 2'b10) cnt++;
        end
`ifdef PWM_GATE_EN
        chk("pwm_on_0", cnt, 0);
`else
        chk("pwm_on_0", cnt, 16);
`endif
        I = 3'b000; cyc();
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
